// File: rtl/parity_checker_if.sv
// Serial bit-stream and frame-result bundle for the parity checker.
// The master side drives the line; the slave side is the checker.
interface parity_checker_if #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
);
    logic              bit_valid;
    logic              bit_in;
    logic [DATA_W-1:0] data_out;
    logic              frame_valid;
    logic              parity_err;
    logic              frame_err;
    logic [CNT_W-1:0]  err_count;
    logic              busy;

    modport master (
        output bit_valid,
        output bit_in,
        input  data_out,
        input  frame_valid,
        input  parity_err,
        input  frame_err,
        input  err_count,
        input  busy
    );

    modport slave (
        input  bit_valid,
        input  bit_in,
        output data_out,
        output frame_valid,
        output parity_err,
        output frame_err,
        output err_count,
        output busy
    );
endinterface

// File: rtl/parity_checker.sv
// Receive-side even-parity checker: reassembles start/data/parity/stop
// frames and reports data, error flags and a saturating error count.
module parity_checker #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input logic          clk,
    input logic          rst,
    parity_checker_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rpar_q, rpar_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fv_q, fv_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic [CNT_W-1:0]  ec_q, ec_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        rpar_d  = rpar_q;
        perr_d  = perr_q;
        data_d  = data_q;
        fv_d    = 1'b0;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ec_d    = ec_q;
        if (bus.bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.bit_in) begin
                        state_d = DATA;
                        shreg_d = '0;
                        cnt_d   = '0;
                        rpar_d  = 1'b0;
                    end
                end
                DATA: begin
                    shreg_d = (shreg_q << 1) | DATA_W'(bus.bit_in);
                    rpar_d  = rpar_q ^ bus.bit_in;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1))
                        state_d = PARITY;
                end
                PARITY: begin
                    perr_d  = rpar_q ^ bus.bit_in;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    data_d  = shreg_q;
                    pe_d    = perr_q;
                    fe_d    = ~bus.bit_in;
                    fv_d    = 1'b1;
                    // one increment per bad frame, even with both errors
                    if ((perr_q | ~bus.bit_in) && (ec_q != '1))
                        ec_d = ec_q + CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            rpar_q  <= 1'b0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            fv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ec_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rpar_q  <= rpar_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            fv_q    <= fv_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ec_q    <= ec_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.frame_valid = fv_q;
    assign bus.parity_err  = pe_q;
    assign bus.frame_err   = fe_q;
    assign bus.err_count   = ec_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_parity_checker.sv
// Bench for parity_checker: directed and randomized frames on a default
// instance and a CNT_W=2 instance, checked against a frame-level model.
module tb_parity_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic v0 = 1'b0, b0 = 1'b1;
    logic v1 = 1'b0, b1 = 1'b1;

    parity_checker_if #(.DATA_W(3), .CNT_W(8)) bus_a ();
    parity_checker_if #(.DATA_W(3), .CNT_W(2)) bus_b ();

    assign bus_a.bit_valid = v0;
    assign bus_a.bit_in    = b0;
    assign bus_b.bit_valid = v1;
    assign bus_b.bit_in    = b1;

    parity_checker #(.DATA_W(3), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    parity_checker #(.DATA_W(3), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks   = 0;
    int failures = 0;
    int exp_cnt[2];
    int cnt_max[2];
    logic [2:0] exp_data[2];
    logic       exp_pe[2];
    logic       exp_fe[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic b);
        if (sel == 0) begin v0 = v; b0 = b; end
        else begin v1 = v; b1 = b; end
    endtask

    task automatic observe(input int sel, output logic fv,
                           output logic busy, output logic pe,
                           output logic fe, output logic [2:0] d,
                           output logic [7:0] ec);
        if (sel == 0) begin
            fv = bus_a.frame_valid; busy = bus_a.busy;
            pe = bus_a.parity_err; fe = bus_a.frame_err;
            d = bus_a.data_out; ec = bus_a.err_count;
        end else begin
            fv = bus_b.frame_valid; busy = bus_b.busy;
            pe = bus_b.parity_err; fe = bus_b.frame_err;
            d = bus_b.data_out; ec = {6'd0, bus_b.err_count};
        end
    endtask

    // Full output check against the model's expectation for one DUT.
    task automatic check_all(input int sel, input string tag,
                             input logic efv, input logic ebusy);
        logic fv, busy, pe, fe;
        logic [2:0] d;
        logic [7:0] ec;
        observe(sel, fv, busy, pe, fe, d, ec);
        chk({tag, ".fv"}, 32'(fv), 32'(efv));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
        chk({tag, ".data"}, 32'(d), 32'(exp_data[sel]));
        chk({tag, ".perr"}, 32'(pe), 32'(exp_pe[sel]));
        chk({tag, ".ferr"}, 32'(fe), 32'(exp_fe[sel]));
        chk({tag, ".cnt"}, 32'(ec), 32'(exp_cnt[sel]));
    endtask

    // Idle-gap cycles hold valid low; the accepted bit follows.
    task automatic send_bit(input int sel, input logic b, input int gap,
                            input logic ebusy_in_gap);
        logic fv, busy, pe, fe;
        logic [2:0] d;
        logic [7:0] ec;
        repeat (gap) begin
            @(negedge clk);
            drive(sel, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            observe(sel, fv, busy, pe, fe, d, ec);
            chk("gap.fv", 32'(fv), 32'd0);
            chk("gap.busy", 32'(busy), 32'(ebusy_in_gap));
        end
        @(negedge clk);
        drive(sel, 1'b1, b);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b1);
    endtask

    task automatic send_frame(input int sel, input logic [2:0] data,
                              input logic p, input logic stop,
                              input int max_gap, input int idles);
        logic [5:0] bits;
        logic perr;
        bits = {1'b0, data, p, stop};
        for (int i = 0; i < idles; i++) begin
            send_bit(sel, 1'b1, $urandom_range(max_gap, 0), 1'b0);
            check_all(sel, "idle", 1'b0, 1'b0);
        end
        for (int i = 5; i >= 1; i--) begin
            send_bit(sel, bits[i], $urandom_range(max_gap, 0),
                     i != 5);
            check_all(sel, "mid", 1'b0, 1'b1);
        end
        send_bit(sel, stop, $urandom_range(max_gap, 0), 1'b1);
        perr = (^data) ^ p;
        exp_data[sel] = data;
        exp_pe[sel]   = perr;
        exp_fe[sel]   = ~stop;
        if ((perr || !stop) && exp_cnt[sel] < cnt_max[sel])
            exp_cnt[sel] = exp_cnt[sel] + 1;
        check_all(sel, "done", 1'b1, 1'b0);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            exp_cnt[s] = 0; exp_data[s] = '0;
            exp_pe[s] = 1'b0; exp_fe[s] = 1'b0;
        end
    endtask

    initial begin
        int sel;
        logic [2:0] d;
        cnt_max[0] = 255;
        cnt_max[1] = 3;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all(0, "rst_a", 1'b0, 1'b0);
        check_all(1, "rst_b", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        send_frame(0, 3'b101, 1'b0, 1'b1, 0, 0);

        for (int i = 0; i < 8; i++) begin
            d = 3'(i);
            send_frame(0, d, ^d, 1'b1, 0, 0);
        end

        send_frame(0, 3'b011, 1'b1, 1'b1, 0, 0);
        send_frame(0, 3'b011, 1'b0, 1'b1, 0, 0);
        send_frame(0, 3'b110, 1'b0, 1'b0, 0, 0);
        send_frame(0, 3'b010, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            d = 3'($urandom);
            sel = ($urandom_range(3, 0) == 0) ? 1 : 0;
            send_frame(sel, d,
                       (^d) ^ ($urandom_range(3, 0) == 0),
                       $urandom_range(3, 0) != 0,
                       5, $urandom_range(3, 0));
        end

        // abandon a frame with reset after the second data bit
        send_bit(0, 1'b0, 0, 1'b0);
        send_bit(0, 1'b1, 0, 1'b1);
        send_bit(0, 1'b0, 0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b1);
        model_reset();
        check_all(0, "midrst", 1'b0, 1'b0);
        check_all(1, "midrst_b", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all(0, "postrst", 1'b0, 1'b0);
        send_frame(0, 3'b110, 1'b0, 1'b1, 2, 1);

        for (int i = 0; i < 5; i++) begin
            d = 3'($urandom);
            send_frame(1, d, ~(^d), 1'b1, 1, 0);
            chk("sat_seq", 32'(bus_b.err_count),
                32'((i < 3) ? i + 1 : 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
